// File: rtl/ddmtd_loop_filter.sv
// DDMTD phase-detector loop filter: PI controller producing a saturated oscillator tuning word.
// A phase_err sample is captured in IDLE, integrated in INTEG, summed with the proportional
// term in SUM, and offered on a valid/ready handshake in OUT. Samples arriving while busy are
// discarded and flagged on sample_drop.
//
// Ports:
//   clk_sys      system clock, rising edge
//   rst          asynchronous active-high reset
//   phase_valid  one-cycle strobe qualifying phase_err
//   phase_err    signed 18-bit phase error
//   clr_flags    synchronous clear of overflow
//   tune_ready   downstream accepts tune_word
//   tune_valid   tune_word valid, held until accepted
//   tune_word    signed saturated tuning word
//   locked       loop-lock indicator
//   overflow     sticky saturation flag
//   sample_drop  one-cycle pulse per discarded sample
//   busy         FSM not in IDLE
module ddmtd_loop_filter #(
  parameter int unsigned KP_SHIFT    = 4,
  parameter int unsigned KI_SHIFT    = 8,
  parameter int unsigned LOCK_THRESH = 64,
  parameter int unsigned LOCK_COUNT  = 16
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               phase_valid,
  input  logic signed [17:0] phase_err,
  input  logic               clr_flags,
  input  logic               tune_ready,
  output logic               tune_valid,
  output logic signed [15:0] tune_word,
  output logic               locked,
  output logic               overflow,
  output logic               sample_drop,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_COUNT);

  localparam logic signed [24:0] IntegMax = 25'sd8388607;
  localparam logic signed [24:0] IntegMin = -25'sd8388608;
  localparam logic signed [24:0] TuneMax  = 25'sd32767;
  localparam logic signed [24:0] TuneMin  = -25'sd32768;

  typedef enum logic [1:0] {StIdle, StInteg, StSum, StOut} state_e;

  state_e             state_q, state_d;
  logic signed [17:0] err_q, err_d;
  logic signed [23:0] integ_q, integ_d;
  logic signed [15:0] tune_word_q, tune_word_d;
  logic               tune_valid_q, tune_valid_d;
  logic [CntW-1:0]    lock_cnt_q, lock_cnt_d;
  logic               locked_q, locked_d;
  logic               overflow_q, overflow_d;
  logic               sample_drop_q, sample_drop_d;

  // Full-width (25-bit) arithmetic so nothing wraps before the clamp.
  logic signed [24:0] err_ext, integ_ext, integ_sum, tune_sum;
  logic signed [23:0] integ_clamped;
  logic signed [15:0] tune_clamped;
  logic               integ_sat, tune_sat;
  logic [18:0]        err_wide, abs_err;
  logic               in_lock;

  assign err_ext   = {{7{err_q[17]}}, err_q};
  assign integ_ext = {integ_q[23], integ_q};
  assign integ_sum = integ_ext + (err_ext >>> KI_SHIFT);
  assign tune_sum  = integ_ext + (err_ext >>> KP_SHIFT);

  // 19 bits so that |-131072| stays positive and falls out of lock.
  assign err_wide = {phase_err[17], phase_err};
  assign abs_err  = phase_err[17] ? (19'd0 - err_wide) : err_wide;
  assign in_lock  = ({13'd0, abs_err} <= LOCK_THRESH);

  always_comb begin
    integ_sat     = 1'b0;
    integ_clamped = integ_sum[23:0];
    if (integ_sum > IntegMax) begin
      integ_sat     = 1'b1;
      integ_clamped = IntegMax[23:0];
    end else if (integ_sum < IntegMin) begin
      integ_sat     = 1'b1;
      integ_clamped = IntegMin[23:0];
    end
  end

  always_comb begin
    tune_sat     = 1'b0;
    tune_clamped = tune_sum[15:0];
    if (tune_sum > TuneMax) begin
      tune_sat     = 1'b1;
      tune_clamped = TuneMax[15:0];
    end else if (tune_sum < TuneMin) begin
      tune_sat     = 1'b1;
      tune_clamped = TuneMin[15:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    integ_d       = integ_q;
    tune_word_d   = tune_word_q;
    tune_valid_d  = tune_valid_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    // A clamp on this edge overrides the clear below.
    overflow_d    = overflow_q & ~clr_flags;
    sample_drop_d = phase_valid & (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (phase_valid) begin
          err_d   = phase_err;
          state_d = StInteg;
          if (in_lock) begin
            if (lock_cnt_q != CntMax) lock_cnt_d = lock_cnt_q + CntW'(1);
            if (lock_cnt_d == CntMax) locked_d = 1'b1;
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end
      end
      StInteg: begin
        integ_d = integ_clamped;
        if (integ_sat) overflow_d = 1'b1;
        state_d = StSum;
      end
      StSum: begin
        tune_word_d  = tune_clamped;
        tune_valid_d = 1'b1;
        if (tune_sat) overflow_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (tune_ready) begin
          tune_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      err_q         <= '0;
      integ_q       <= '0;
      tune_word_q   <= '0;
      tune_valid_q  <= 1'b0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
      overflow_q    <= 1'b0;
      sample_drop_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      integ_q       <= integ_d;
      tune_word_q   <= tune_word_d;
      tune_valid_q  <= tune_valid_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
      overflow_q    <= overflow_d;
      sample_drop_q <= sample_drop_d;
    end
  end

  assign tune_valid  = tune_valid_q;
  assign tune_word   = tune_word_q;
  assign locked      = locked_q;
  assign overflow    = overflow_q;
  assign sample_drop = sample_drop_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ddmtd_loop_filter.sv
// Self-checking bench for ddmtd_loop_filter: vector table, scoreboard on the tune handshake,
// and directed sequences for reset, backpressure, saturation and lock.
module tb_ddmtd_loop_filter;

  localparam int KpShift    = 4;
  localparam int KiShift    = 8;
  localparam int LockThresh = 64;
  localparam int LockCount  = 16;

  logic               clk_sys     = 1'b0;
  logic               rst         = 1'b1;
  logic               phase_valid = 1'b0;
  logic signed [17:0] phase_err   = '0;
  logic               clr_flags   = 1'b0;
  logic               tune_ready  = 1'b0;
  logic               tune_valid;
  logic signed [15:0] tune_word;
  logic               locked;
  logic               overflow;
  logic               sample_drop;
  logic               busy;

  int n_vec  = 0;
  int n_err  = 0;
  int n_xfer = 0;
  int exp_q[$];
  int m_integ = 0;
  int last_lat, last_busy;
  bit locked_at_cap;

  typedef struct {
    int err;
    int exp_tune;
  } vec_t;
  vec_t vecs[8];

  ddmtd_loop_filter #(
    .KP_SHIFT   (KpShift),
    .KI_SHIFT   (KiShift),
    .LOCK_THRESH(LockThresh),
    .LOCK_COUNT (LockCount)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .phase_valid(phase_valid),
    .phase_err  (phase_err),
    .clr_flags  (clr_flags),
    .tune_ready (tune_ready),
    .tune_valid (tune_valid),
    .tune_word  (tune_word),
    .locked     (locked),
    .overflow   (overflow),
    .sample_drop(sample_drop),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Floor division by 2^s, written without relying on >>>.
  function automatic int fshift(input int v, input int s);
    int d;
    d = 1 << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_sample(input int err);
    int t;
    m_integ = clampi(m_integ + fshift(err, KiShift), -8388608, 8388607);
    t = clampi(fshift(err, KpShift) + m_integ, -32768, 32767);
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drive one accepted sample and wait until tune_valid rises.
  task automatic start_sample(input int err);
    model_sample(err);
    phase_err   = 18'(err);
    phase_valid = 1'b1;
    tick();
    phase_valid   = 1'b0;
    locked_at_cap = locked;
    last_busy     = busy ? 1 : 0;
    last_lat      = 0;
    while (!tune_valid && last_lat < 8) begin
      tick();
      last_lat++;
      if (busy) last_busy++;
    end
    check("tune_valid_seen", int'(tune_valid), 1);
  endtask

  task automatic run_sample(input int err);
    start_sample(err);
    tick();
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    @(posedge clk_sys);
    #1;
    rst     = 1'b0;
    m_integ = 0;
    exp_q.delete();
  endtask

  // Scoreboard: a transfer happens on the next edge when valid and ready are both high now.
  always @(negedge clk_sys) begin
    if (!rst && tune_valid && tune_ready) begin
      n_xfer++;
      check("sb_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sb_tune_word", int'(tune_word), exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int tw, x0, drops;

    vecs[0] = '{4096, 272};
    vecs[1] = '{-1, 14};
    vecs[2] = '{-4096, -257};
    vecs[3] = '{255, 14};
    vecs[4] = '{-17, -4};
    vecs[5] = '{64, 2};
    vecs[6] = '{-131072, -8706};
    vecs[7] = '{131071, 8188};

    // Reset state
    #3;
    check("rst_tune_valid", int'(tune_valid), 0);
    check("rst_tune_word", int'(tune_word), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_sample_drop", int'(sample_drop), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // Reset mid-operation in OUT abandons the result
    phase_err   = 18'sd4096;
    phase_valid = 1'b1;
    tick();
    phase_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", int'(tune_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(tune_valid), 0);
    check("async_rst_word", int'(tune_word), 0);
    check("async_rst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("held_valid_low", int'(tune_valid), 0);
    end

    // Vector table from reset, first row also checks latency and busy span
    tune_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      start_sample(vecs[i].err);
      if (i == 0) begin
        check("latency_edges", last_lat, 2);
        check("busy_cycles_to_valid", last_busy, 3);
      end
      check($sformatf("vec%0d_tune_word", i), int'(tune_word), vecs[i].exp_tune);
      check($sformatf("vec%0d_locked", i), int'(locked), 0);
      check($sformatf("vec%0d_overflow", i), int'(overflow), 0);
      tick();
      if (i == 0) begin
        check("idle_after_xfer_busy", int'(busy), 0);
        check("idle_after_xfer_valid", int'(tune_valid), 0);
      end
    end

    // Rounding toward negative infinity
    apply_reset();
    start_sample(-1);
    check("round_tune_word", int'(tune_word), -2);
    tick();
    start_sample(0);
    check("round_integ_is_m1", int'(tune_word), -1);
    tick();

    // Lock acquisition
    apply_reset();
    for (int k = 0; k < 15; k++) run_sample(10);
    check("lock_after_15", int'(locked), 0);
    start_sample(10);
    check("lock_on_16th_capture", int'(locked_at_cap), 1);
    tick();

    // Backpressure with a dropped out-of-lock sample
    tune_ready = 1'b0;
    start_sample(10);
    tw    = tune_word;
    x0    = n_xfer;
    drops = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        phase_err   = 18'sd65;
        phase_valid = 1'b1;
      end
      tick();
      phase_valid = 1'b0;
      if (sample_drop) drops++;
      check("bp_word_stable", int'(tune_word), tw);
      check("bp_valid_held", int'(tune_valid), 1);
    end
    check("bp_drop_pulses", drops, 1);
    check("bp_locked_kept", int'(locked), 1);
    // Release with a sample on the transfer edge: dropped too
    tune_ready  = 1'b1;
    phase_err   = 18'sd65;
    phase_valid = 1'b1;
    tick();
    phase_valid = 1'b0;
    check("xfer_edge_drop", int'(sample_drop), 1);
    check("xfer_edge_idle", int'(busy), 0);
    check("xfer_edge_locked", int'(locked), 1);
    tick();
    check("drop_one_cycle", int'(sample_drop), 0);
    check("single_transfer", n_xfer - x0, 1);
    check("word_held_after_xfer", int'(tune_word), tw);

    // Loss of lock and re-acquisition
    start_sample(65);
    check("unlock_on_capture", int'(locked_at_cap), 0);
    tick();
    for (int k = 0; k < 15; k++) run_sample(10);
    check("relock_after_15", int'(locked), 0);
    run_sample(10);
    check("relock_after_16", int'(locked), 1);

    // Saturation and sticky overflow
    apply_reset();
    for (int n = 1; n <= 55; n++) begin
      start_sample(131071);
      if (n == 48) begin
        check("sat48_tune_word", int'(tune_word), 32719);
        check("sat48_overflow", int'(overflow), 0);
      end
      if (n == 49) begin
        check("sat49_tune_word", int'(tune_word), 32767);
        check("sat49_overflow", int'(overflow), 1);
      end
      if (n == 55) begin
        check("sat55_tune_word", int'(tune_word), 32767);
        check("sat55_overflow", int'(overflow), 1);
      end
      tick();
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_overflow", int'(overflow), 0);
    tick();
    tick();
    check("overflow_stays_clear", int'(overflow), 0);
    // Clamp and clear on the same edge: overflow stays set
    clr_flags = 1'b1;
    start_sample(131071);
    check("clamp_beats_clear", int'(overflow), 1);
    clr_flags = 1'b0;
    tick();
    check("overflow_resticky", int'(overflow), 1);

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddmtd_loop_filter.md
DDMTD_LOOP_FILTER -- requirements
Module: ddmtd_loop_filter

Interface
REQ-001 Parameter KP_SHIFT, default 4: proportional gain 2^-KP_SHIFT.
REQ-002 Parameter KI_SHIFT, default 8: integral gain 2^-KI_SHIFT.
REQ-003 Parameter LOCK_THRESH, default 64: maximum |phase_err| counted as in-lock.
REQ-004 Parameter LOCK_COUNT, default 16: consecutive in-lock samples required to assert locked.
REQ-005 clk_sys  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 phase_valid  in  1  one-cycle strobe marking a new phase_err sample.
REQ-008 phase_err  in  18  signed phase error sample.
REQ-009 clr_flags  in  1  synchronous clear of overflow.
REQ-010 tune_ready  in  1  downstream accepts tune_word.
REQ-011 tune_valid  out  1  tune_word is valid; held until accepted.
REQ-012 tune_word  out  16  signed, saturated oscillator tuning word.
REQ-013 locked  out  1  loop-lock indicator.
REQ-014 overflow  out  1  sticky saturation flag.
REQ-015 sample_drop  out  1  one-cycle pulse when a sample is discarded.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, INTEG, SUM and OUT.
REQ-018 IDLE: on phase_valid=1, capture phase_err into err_q and go to INTEG.
REQ-019 INTEG: integ <= clamp24(integ + (err_q >>> KI_SHIFT)); go to SUM.
REQ-020 SUM: tune_word <= clamp16((err_q >>> KP_SHIFT) + integ); set tune_valid; go to OUT.
REQ-021 Shifts SHALL be arithmetic, rounding toward negative infinity; sums SHALL be computed at full width before clamping.
REQ-022 clamp24 range: [-2^23, 2^23-1]; clamp16 range: [-32768, 32767].
REQ-023 Any clamp that alters a value SHALL set overflow on the same edge.
REQ-024 overflow SHALL stay set until reset or clr_flags=1; if a clamp and clr_flags occur on the same edge, overflow SHALL remain set.
REQ-025 Latency: with phase_valid sampled at edge 0, tune_valid SHALL be high after edge 2, i.e. in the third cycle after the sample.
REQ-026 OUT: a transfer SHALL occur on an edge where tune_valid=1 and tune_ready=1; tune_valid SHALL then clear and the FSM SHALL return to IDLE.
REQ-027 tune_word SHALL hold its value while tune_valid=1 and after the transfer, until the next SUM.
REQ-028 phase_valid=1 in any state other than IDLE, including the OUT transfer cycle, SHALL discard the sample, pulse sample_drop for one cycle, and leave integ and the lock counter unchanged.
REQ-029 On each IDLE capture, if |phase_err| <= LOCK_THRESH, the lock counter SHALL increment, saturating at LOCK_COUNT; otherwise the counter and locked SHALL clear on that edge.
REQ-030 locked SHALL be set on the capture edge on which the lock counter reaches LOCK_COUNT.
REQ-031 |phase_err| for -131072 SHALL be treated as 131072 (out of lock).

Reset
REQ-032 rst=1 SHALL immediately and asynchronously force: FSM to IDLE, integ=0, err_q=0, lock counter=0, tune_word=0, tune_valid=0, locked=0, overflow=0, sample_drop=0, busy=0.
REQ-033 Reset asserted mid-operation, in INTEG, SUM or OUT, SHALL abandon the pending result with no transfer.
REQ-034 After rst falls, the first phase_valid SHALL be accepted on the next rising edge.

Verification
REQ-035 Reset: pulse rst asynchronously between edges -> all outputs 0 immediately; hold tune_ready=0 -> tune_valid stays 0.
REQ-036 Single sample with default parameters, phase_err=+4096, tune_ready=1 -> tune_valid high in the third cycle, tune_word=272 (integ=16, proportional term 256), busy for 3 cycles.
REQ-037 Rounding, starting from reset, phase_err=-1 -> integ=-1, tune_word=-2.
REQ-038 Backpressure: hold tune_ready=0 for 5 cycles after tune_valid and inject phase_valid -> sample_drop pulses once, tune_word stable, integ unchanged; release tune_ready -> single transfer, then IDLE.
REQ-039 Saturation: repeated phase_err=+131071 -> tune_word=32767 from sample 49 onward, overflow=1; clr_flags -> overflow=0 until the next clamp.
REQ-040 Lock: 16 samples of phase_err=+10 -> locked=1 on the 16th capture edge; then phase_err=+65 -> locked=0 on that capture edge; then 15 samples of +10 -> locked stays 0.
